// File: rtl/endless_wave_pkg.sv
// Shared constants and state encoding for the Endless Wave obstacle path.
package endless_wave_pkg;

  localparam int           SCREEN_H    = 120;
  localparam logic [6:0]   SPAWN_Y_MIN = 7'd8;
  localparam logic [6:0]   LFSR_SEED   = 7'h5A;
  localparam logic [2:0]   SPEED_MAX   = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    RUN,
    CHECK,
    HALT
  } obst_state_t;

  // Gap top row: low six LFSR bits offset by the minimum, covering 8..71.
  function automatic logic [6:0] spawn_y(input logic [6:0] lfsr);
    return SPAWN_Y_MIN + (lfsr & 7'h3F);
  endfunction

endpackage

// File: rtl/obstacle_gen_if.sv
// Game-control inputs and obstacle geometry outputs of the obstacle generator.
interface obstacle_gen_if;
  logic       start;
  logic       frame_tick;
  logic       crash;
  logic [7:0] obstacles_x;
  logic [6:0] obstacles_y;
  logic [7:0] height;
  logic [4:0] width;
  logic       check_en;
  logic [7:0] score;
  logic [2:0] speed;
  logic       halted;

  modport master (
    input  start, frame_tick, crash,
    output obstacles_x, obstacles_y, height, width, check_en, score, speed, halted
  );

  modport slave (
    output start, frame_tick, crash,
    input  obstacles_x, obstacles_y, height, width, check_en, score, speed, halted
  );
endinterface

// File: rtl/lfsr7.sv
// 7-bit Fibonacci LFSR (x^7+x^6+1); advances only on step.
module lfsr7
  import endless_wave_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  output logic [6:0] value
);

  always_ff @(posedge clk) begin
    if (reset)     value <= LFSR_SEED;
    else if (step) value <= {value[5:0], value[6] ^ value[5]};
  end

endmodule

// File: rtl/obstacle_gen.sv
// Spawns and scrolls one wall/gap obstacle, strobing check_en after each move.
// Define OBSTACLE_SPEEDUP_EN to raise speed every fourth obstacle passed.
module obstacle_gen
  import endless_wave_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int WIDTH    = 10,
  parameter int GAP_H    = 40
) (
  input  logic           clk,
  input  logic           reset,
  obstacle_gen_if.master bus
);

  localparam logic [7:0] X_SPAWN = 8'(SCREEN_W - 1);

  obst_state_t state;
  logic [7:0]  x_r;
  logic [6:0]  y_r;
  logic        chk_r;
  logic [7:0]  score_r;
  logic [7:0]  score_inc;
  logic        halted_r;
  logic [2:0]  speed_r;
  logic [6:0]  lfsr;
  logic        leaving;

  lfsr7 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (state == SPAWN),
    .value (lfsr)
  );

  // Subtracting only when x >= speed keeps x from wrapping.
  assign leaving   = x_r < {5'd0, speed_r};
  assign score_inc = (score_r == 8'hFF) ? score_r : score_r + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      x_r      <= X_SPAWN;
      y_r      <= '0;
      chk_r    <= 1'b0;
      score_r  <= '0;
      halted_r <= 1'b0;
    end else begin
      chk_r <= 1'b0;
      case (state)
        IDLE:  if (bus.start) state <= SPAWN;
        SPAWN: begin
          x_r   <= X_SPAWN;
          y_r   <= spawn_y(lfsr);
          state <= RUN;
        end
        RUN: begin
          if (bus.crash) begin
            halted_r <= 1'b1;
            state    <= HALT;
          end else if (bus.frame_tick) begin
            if (leaving) begin
              score_r <= score_inc;
              state   <= SPAWN;
            end else begin
              x_r   <= x_r - {5'd0, speed_r};
              chk_r <= 1'b1;
              state <= CHECK;
            end
          end
        end
        CHECK: state <= RUN;
        HALT: begin
          if (bus.start) begin
            score_r  <= '0;
            halted_r <= 1'b0;
            state    <= SPAWN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OBSTACLE_SPEEDUP_EN
  always_ff @(posedge clk) begin
    if (reset)
      speed_r <= 3'd1;
    else if (state == HALT && bus.start)
      speed_r <= 3'd1;
    else if (state == RUN && !bus.crash && bus.frame_tick && leaving &&
             score_inc[1:0] == 2'd0 && speed_r < SPEED_MAX)
      speed_r <= speed_r + 3'd1;
  end
`else
  assign speed_r = 3'd1;
`endif

  assign bus.obstacles_x = x_r;
  assign bus.obstacles_y = y_r;
  assign bus.height      = 8'(GAP_H);
  assign bus.width       = 5'(WIDTH);
  assign bus.check_en    = chk_r;
  assign bus.score       = score_r;
  assign bus.speed       = speed_r;
  assign bus.halted      = halted_r;

endmodule

// File: tb/tb_obstacle_gen.sv
// Directed self-checking bench for obstacle_gen (builds with or without OBSTACLE_SPEEDUP_EN).
module tb_obstacle_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  obstacle_gen_if bus ();

  obstacle_gen #(.SCREEN_W(160), .WIDTH(10), .GAP_H(40)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef OBSTACLE_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  int m_x, m_spd, m_score;
  logic [6:0] m_lfsr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lfsr_step();
    m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
  endtask

  // One frame tick from RUN; returns with the DUT back in RUN.
  task automatic do_tick();
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
    if (m_x < m_spd) begin
      m_score = (m_score == 255) ? 255 : m_score + 1;
      if (SPEEDUP && (m_score % 4) == 0 && m_spd < 4) m_spd++;
      chk("respawn_check_en", 32'(bus.check_en), 0);
      chk("respawn_score", 32'(bus.score), 32'(m_score));
      cyc();
      chk("respawn_x", 32'(bus.obstacles_x), 159);
      chk("respawn_y", 32'(bus.obstacles_y), 32'(8 + m_lfsr[5:0]));
      chk("respawn_speed", 32'(bus.speed), 32'(m_spd));
      lfsr_step();
      m_x = 159;
    end else begin
      m_x -= m_spd;
      chk("tick_x", 32'(bus.obstacles_x), 32'(m_x));
      chk("tick_check_en", 32'(bus.check_en), 1);
      cyc();
      chk("check_en_drop", 32'(bus.check_en), 0);
    end
  endtask

  task automatic start_game();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0;
    bus.frame_tick = 1'b0;
    bus.crash = 1'b0;
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();

    chk("rst_x", 32'(bus.obstacles_x), 159);
    chk("rst_y", 32'(bus.obstacles_y), 0);
    chk("rst_check_en", 32'(bus.check_en), 0);
    chk("rst_score", 32'(bus.score), 0);
    chk("rst_speed", 32'(bus.speed), 1);
    chk("rst_halted", 32'(bus.halted), 0);

    // First spawn: seed 0x5A -> y = 8 + 0x1A = 34
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("spawn_cycle_y_old", 32'(bus.obstacles_y), 0);
    cyc();
    chk("spawn_x", 32'(bus.obstacles_x), 159);
    chk("spawn_y", 32'(bus.obstacles_y), 34);
    chk("height", 32'(bus.height), 40);
    chk("width", 32'(bus.width), 10);
    chk("spawn_check_en", 32'(bus.check_en), 0);

    m_x = 159; m_spd = 1; m_score = 0; m_lfsr = 7'h35;
    for (int i = 0; i < 159; i++) do_tick();
    chk("x_at_edge", 32'(bus.obstacles_x), 0);
    do_tick();
    chk("second_score", 32'(bus.score), 1);
    chk("second_y", 32'(bus.obstacles_y), 61);

    // Crash beats a simultaneous tick
    do_tick();
    bus.crash = 1'b1;
    bus.frame_tick = 1'b1;
    cyc();
    bus.crash = 1'b0;
    bus.frame_tick = 1'b0;
    chk("crash_halted", 32'(bus.halted), 1);
    chk("crash_x", 32'(bus.obstacles_x), 158);
    chk("crash_check_en", 32'(bus.check_en), 0);
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
    cyc();
    chk("halt_hold_x", 32'(bus.obstacles_x), 158);
    chk("halt_hold_score", 32'(bus.score), 1);
    chk("halt_hold_halted", 32'(bus.halted), 1);

    // Restart: LFSR continues 0x6B -> y = 8 + 0x2B = 51
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("restart_score", 32'(bus.score), 0);
    chk("restart_halted", 32'(bus.halted), 0);
    cyc();
    chk("restart_x", 32'(bus.obstacles_x), 159);
    chk("restart_y", 32'(bus.obstacles_y), 51);
    m_x = 159; m_spd = 1; m_score = 0; m_lfsr = 7'h56;

    while (m_score < 4) do_tick();
    chk("speed_after_4", 32'(bus.speed), SPEEDUP ? 2 : 1);
    do_tick();
    chk("x_after_speedup", 32'(bus.obstacles_x), SPEEDUP ? 157 : 158);
    while (m_score < 8) do_tick();
    chk("speed_after_8", 32'(bus.speed), SPEEDUP ? 3 : 1);
    chk("score_8", 32'(bus.score), 8);

    // Mid-scroll reset at x=80
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    start_game();
    chk("reseed_y", 32'(bus.obstacles_y), 34);
    m_x = 159; m_spd = 1; m_score = 0; m_lfsr = 7'h35;
    for (int i = 0; i < 79; i++) do_tick();
    chk("mid_x", 32'(bus.obstacles_x), 80);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midrst_x", 32'(bus.obstacles_x), 159);
    chk("midrst_y", 32'(bus.obstacles_y), 0);
    chk("midrst_score", 32'(bus.score), 0);
    chk("midrst_check_en", 32'(bus.check_en), 0);
    chk("midrst_speed", 32'(bus.speed), 1);
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
    chk("idle_ignores_tick", 32'(bus.obstacles_x), 159);
    start_game();
    chk("midrst_respawn_y", 32'(bus.obstacles_y), 34);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/obstacle_gen.md
# obstacle_gen

Obstacle generator for the Endless Wave game: produces the scrolling wall/gap geometry consumed by the collision checker and the renderer. It spawns one obstacle at the right screen edge, gives it a pseudo-random gap position, and scrolls it left by `speed` pixels per frame tick. After every position update it issues a one-cycle `check_en` strobe so the checker evaluates against the new geometry. On a reported crash it freezes until restarted.

## Interface
- `SCREEN_W`, 160: screen width in pixels. The spawn x is `SCREEN_W-1`.
- `WIDTH`, 10: obstacle width in pixels; driven constant on `width`.
- `GAP_H`, 40: gap height in pixels; driven constant on `height`. Must be ≤ `SCREEN_H`-72.
- `clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: level-sampled; begins or restarts a game.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `crash` in 1: collision flag from the collision checker.
- `obstacles_x` out 8: obstacle left edge.
- `obstacles_y` out 7: gap top row.
- `height` out 8: gap height, equal to `GAP_H`.
- `width` out 5: obstacle width, equal to `WIDTH`.
- `check_en` out 1: one-cycle strobe telling the checker to evaluate.
- `score` out 8: number of obstacles passed; saturates at 255.
- `speed` out 3: pixels moved per tick, range 1..4.
- `halted` out 1: high while in HALT.

## Operation
- Reset values:
  - `obstacles_x`=159, `obstacles_y`=0, `check_en`=0, `score`=0, `speed`=1, `halted`=0.
  - LFSR=7'h5A. State = IDLE.
- IDLE: outputs hold their reset values. `start`=1 → SPAWN.
- SPAWN (one cycle):
  - `obstacles_x`←`SCREEN_W`-1.
  - `obstacles_y`←8+LFSR[5:0], giving a range of 8..71.
  - LFSR steps: next = {lfsr[5:0], lfsr[6]^lfsr[5]}.
  - → RUN.
- RUN, evaluated in priority order:
  1. `crash`=1 → HALT. Crash beats a simultaneous `frame_tick`.
  2. `frame_tick`=1 and `obstacles_x` < `speed` (obstacle leaves the screen) → `score`+1, speedup rule applied, → SPAWN. No `check_en` is issued for this tick.
  3. `frame_tick`=1 otherwise → `obstacles_x`←`obstacles_x`−`speed`, → CHECK.
- CHECK (one cycle): `check_en`=1, → RUN. A `frame_tick` arriving in CHECK is ignored; ticks are at least 2 cycles apart by construction.
- HALT:
  - All geometry, `score` and `speed` are held; `halted`=1.
  - `start`=1 → `score`←0, `speed`←1, → SPAWN. The LFSR is not reseeded.
- Arithmetic:
  - Subtraction is 8-bit and is only performed when `obstacles_x` ≥ `speed`, so x never wraps.
  - `score` saturates at 255.
- `reset` asserted in any state, mid-scroll included, returns to IDLE with reset values on the next edge.

## Timing
- All outputs are registered.
- `start` sampled at edge N (IDLE) → SPAWN during cycle N+1 → new `obstacles_x`/`obstacles_y` visible from edge N+2.
- `frame_tick` sampled at edge T (RUN) → updated `obstacles_x` and `check_en`=1 both visible in cycle T+1, for exactly one cycle. The checker therefore samples the new geometry at edge T+2.
- `crash` sampled at edge C → `halted`=1 from C+1.
- Respawn on leaving the screen: new geometry is visible 2 cycles after the tick.

## Configuration
- `OBSTACLE_SPEEDUP_EN` defined: on every respawn where the incremented `score`[1:0]==0, `speed`←min(`speed`+1, 4).
- `OBSTACLE_SPEEDUP_EN` undefined: `speed` is constant 1 and the speedup logic is absent.

## Structure
- Shared package `endless_wave_pkg` holds:
  - `SCREEN_H`=120, `SPAWN_Y_MIN`=8, `LFSR_SEED`=7'h5A, `SPEED_MAX`=4.
  - The state enum `obst_state_t` {IDLE, SPAWN, RUN, CHECK, HALT}.
- One sub-module, `lfsr7`: 7-bit Fibonacci LFSR (x^7+x^6+1).
  - Ports: `clk`, `reset`, `step`, `value`[6:0].
  - Reset value is `LFSR_SEED`; it advances only when `step`=1.

## Test plan
- Reset, then `start` → from cycle 2: `obstacles_x`=159, `obstacles_y`=34 (8+0x1A), `height`=40, `width`=10, `check_en`=0.
- 159 ticks at speed 1 → `obstacles_x` steps 158…0, with one `check_en` pulse per tick. The 160th tick → respawn: `score`=1, x=159, `obstacles_y`=61 (LFSR 0x35), and no `check_en`.
- `crash`=1 and `frame_tick`=1 in the same RUN cycle → HALT, x unchanged, no `check_en`, `halted`=1. Then `start` → `score`=0, respawn at x=159.
- With `OBSTACLE_SPEEDUP_EN`: after the 4th respawn, `speed`=2. Then from x=159, ticks give x=157, 155, …; x=1 plus a tick → respawn.
- Without the macro: `speed` stays 1 after 8 respawns.
- `reset` pulsed at x=80 mid-scroll → the next cycle shows IDLE values: x=159, `score`=0, LFSR reseeded, so the next spawn y=34.
